// File: rtl/legv8_control_unit.sv
// rtl/legv8_control_unit.sv - LEGv8 multi-cycle control unit.
// Decodes one instruction per handshake and drives DatapathLEGv8 for one or two cycles.
module legv8_control_unit #(
  parameter logic [63:0] PC_RESET = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instruction,
  output logic        instr_ready,
  input  logic [3:0]  status,
  output logic [24:0] ControlWord,
  output logic [63:0] constant,
  output logic [63:0] pc,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;
  typedef enum logic [1:0] {K_SEQ, K_LDUR, K_CBZ} kind_t;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01010;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  state_t      state, state_next;
  kind_t       kind, dec_kind;
  logic [63:0] step, dec_step, pc_next;
  logic [24:0] dec_cw;
  logic [63:0] dec_const;
  logic        dec_illegal;
  logic        hit;
  logic [4:0]  rn, rm, rd;
  logic [63:0] mem_off, shamt, imm12;
  logic        unused_status;

  function automatic logic [24:0] pack_cw(input logic [4:0] sa, sb, da,
                                          input logic rw, mw,
                                          input logic [4:0] fs,
                                          input logic bsel, en_mem, en_alu);
    return {sa, sb, da, rw, mw, fs, bsel, en_mem, en_alu};
  endfunction

  assign rn            = instruction[9:5];
  assign rm            = instruction[20:16];
  assign rd            = instruction[4:0];
  assign mem_off       = {{55{instruction[20]}}, instruction[20:12]};
  assign shamt         = {58'd0, instruction[15:10]};
  assign imm12         = {52'd0, instruction[21:10]};
  assign instr_ready   = (state == IDLE);
  assign unused_status = ^status[3:1];

  // Opcode widths are tried longest first; dec_step holds the taken-branch PC increment.
  always_comb begin
    dec_cw      = '0;
    dec_const   = '0;
    dec_illegal = 1'b0;
    dec_kind    = K_SEQ;
    dec_step    = 64'd4;
    hit         = 1'b1;
    case (instruction[31:21])
      11'b10001011000: dec_cw = pack_cw(rn, rm, rd, 1'b1, 1'b0, FS_ADD, 1'b0, 1'b0, 1'b1);
      11'b11001011000: dec_cw = pack_cw(rn, rm, rd, 1'b1, 1'b0, FS_SUB, 1'b0, 1'b0, 1'b1);
      11'b10001010000: dec_cw = pack_cw(rn, rm, rd, 1'b1, 1'b0, FS_AND, 1'b0, 1'b0, 1'b1);
      11'b10101010000: dec_cw = pack_cw(rn, rm, rd, 1'b1, 1'b0, FS_ORR, 1'b0, 1'b0, 1'b1);
      11'b11001010000: dec_cw = pack_cw(rn, rm, rd, 1'b1, 1'b0, FS_EOR, 1'b0, 1'b0, 1'b1);
      11'b11010011011: begin
        dec_cw    = pack_cw(rn, rm, rd, 1'b1, 1'b0, FS_LSL, 1'b1, 1'b0, 1'b1);
        dec_const = shamt;
      end
      11'b11010011010: begin
        dec_cw    = pack_cw(rn, rm, rd, 1'b1, 1'b0, FS_LSR, 1'b1, 1'b0, 1'b1);
        dec_const = shamt;
      end
      11'b11111000010: begin
        dec_cw    = pack_cw(rn, 5'd0, rd, 1'b0, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b0);
        dec_const = mem_off;
        dec_kind  = K_LDUR;
      end
      11'b11111000000: begin
        dec_cw    = pack_cw(rn, rd, 5'd0, 1'b0, 1'b1, FS_ADD, 1'b1, 1'b0, 1'b0);
        dec_const = mem_off;
      end
      default: hit = 1'b0;
    endcase
    if (!hit) begin
      hit = 1'b1;
      case (instruction[31:22])
        10'b1001000100: dec_cw = pack_cw(rn, 5'd0, rd, 1'b1, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b1);
        10'b1101000100: dec_cw = pack_cw(rn, 5'd0, rd, 1'b1, 1'b0, FS_SUB, 1'b1, 1'b0, 1'b1);
        default:        hit = 1'b0;
      endcase
      if (hit) dec_const = imm12;
    end
    if (!hit) begin
      if (instruction[31:24] == 8'b10110100) begin
        dec_cw   = pack_cw(rd, 5'd0, 5'd0, 1'b0, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b0);
        dec_kind = K_CBZ;
        dec_step = {{43{instruction[23]}}, instruction[23:5], 2'b00};
      end else if (instruction[31:26] == 6'b000101) begin
        dec_step = {{36{instruction[25]}}, instruction[25:0], 2'b00};
      end else begin
        dec_illegal = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc + step;
    case (state)
      IDLE:    if (instr_valid) state_next = EXEC;
      EXEC:    state_next = (kind == K_LDUR) ? MEM : IDLE;
      MEM:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kind == K_CBZ && !status[0]) pc_next = pc + 64'd4;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      kind        <= K_SEQ;
      step        <= 64'd4;
      pc          <= PC_RESET;
      ControlWord <= '0;
      constant    <= '0;
      illegal     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            kind        <= dec_kind;
            step        <= dec_step;
            ControlWord <= dec_cw;
            constant    <= dec_const;
            illegal     <= dec_illegal;
          end
        end
        EXEC: begin
          if (kind == K_LDUR) begin
            // Load write-back cycle: enable memory read and register write.
            ControlWord[9] <= 1'b1;
            ControlWord[1] <= 1'b1;
          end else begin
            ControlWord <= '0;
            constant    <= '0;
            illegal     <= 1'b0;
            pc          <= pc_next;
          end
        end
        default: begin
          ControlWord <= '0;
          constant    <= '0;
          illegal     <= 1'b0;
          pc          <= pc_next;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_control_unit.sv
// tb/tb_legv8_control_unit.sv - self-checking bench for legv8_control_unit.
module tb_legv8_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic [3:0]  status = 4'd0;
  logic        instr_ready;
  logic [24:0] ControlWord;
  logic [63:0] constant;
  logic [63:0] pc;
  logic        illegal;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_pc = 64'd0;

  legv8_control_unit dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .instr_ready (instr_ready),
    .status      (status),
    .ControlWord (ControlWord),
    .constant    (constant),
    .pc          (pc),
    .illegal     (illegal)
  );

  always #5 clock = ~clock;

  typedef enum int {M_ADD, M_SUB, M_AND, M_ORR, M_EOR, M_LSL, M_LSR, M_ADDI, M_SUBI,
                    M_LDUR, M_STUR, M_CBZ, M_B, M_ILL} mnem_t;

  typedef struct {
    logic [10:0] val;
    int          width;
    mnem_t       m;
  } opdesc_t;

  typedef struct {
    logic [31:0] w;
    logic [3:0]  st;
    logic [24:0] cw;
    logic [24:0] cw_mem;
    logic [63:0] cst;
    logic        ill;
    logic        ldur;
    logic [63:0] pc_after;
  } vec_t;

  opdesc_t ops [13] = '{
    '{11'b10001011000, 11, M_ADD},  '{11'b11001011000, 11, M_SUB},
    '{11'b10001010000, 11, M_AND},  '{11'b10101010000, 11, M_ORR},
    '{11'b11001010000, 11, M_EOR},  '{11'b11010011011, 11, M_LSL},
    '{11'b11010011010, 11, M_LSR},  '{11'b11111000010, 11, M_LDUR},
    '{11'b11111000000, 11, M_STUR}, '{11'b01001000100, 10, M_ADDI},
    '{11'b01101000100, 10, M_SUBI}, '{11'b00010110100, 8,  M_CBZ},
    '{11'b00000000101, 6,  M_B}
  };

  localparam logic [24:0] ADD_CW = 25'b00010_00000_00101_1_0_01000_0_0_1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic mnem_t classify(input logic [31:0] w);
    int widths [4] = '{11, 10, 8, 6};
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 13; i++)
        if (ops[i].width == widths[k] && (w >> (32 - widths[k])) == 32'(ops[i].val))
          return ops[i].m;
    return M_ILL;
  endfunction

  function automatic logic [4:0] alu_fs(input int op, input logic binv);
    return {3'(op), binv, 1'b0};
  endfunction

  function automatic vec_t model(input logic [31:0] w, input logic [3:0] st, input logic [63:0] pc_now);
    vec_t v;
    mnem_t m;
    logic [4:0] sa, sb, da, fs;
    logic rw, mw, bsel, en_mem, en_alu;
    m = classify(w);
    v.w = w; v.st = st; v.cst = 64'd0; v.ill = 1'b0; v.ldur = 1'b0; v.cw_mem = 25'd0;
    sa = 5'd0; sb = 5'd0; da = 5'd0; rw = 1'b0; mw = 1'b0; bsel = 1'b0; en_mem = 1'b0; en_alu = 1'b0;
    case (m)
      M_ADD, M_SUB, M_AND, M_ORR, M_EOR: begin
        sa = w[9:5]; sb = w[20:16]; da = w[4:0]; rw = 1'b1; en_alu = 1'b1;
      end
      M_LSL, M_LSR: begin
        sa = w[9:5]; sb = w[20:16]; da = w[4:0]; rw = 1'b1; en_alu = 1'b1; bsel = 1'b1;
        v.cst = 64'(w[15:10]);
      end
      M_ADDI, M_SUBI: begin
        sa = w[9:5]; da = w[4:0]; rw = 1'b1; en_alu = 1'b1; bsel = 1'b1;
        v.cst = 64'(w[21:10]);
      end
      M_LDUR: begin
        sa = w[9:5]; da = w[4:0]; bsel = 1'b1; v.ldur = 1'b1;
        v.cst = 64'(longint'($signed(w[20:12])));
      end
      M_STUR: begin
        sa = w[9:5]; sb = w[4:0]; mw = 1'b1; bsel = 1'b1;
        v.cst = 64'(longint'($signed(w[20:12])));
      end
      M_CBZ: begin
        sa = w[4:0]; bsel = 1'b1;
      end
      M_ILL: v.ill = 1'b1;
      default: ;
    endcase
    case (m)
      M_SUB, M_SUBI: fs = alu_fs(2, 1'b1);
      M_AND:         fs = alu_fs(0, 1'b0);
      M_ORR:         fs = alu_fs(1, 1'b0);
      M_EOR:         fs = alu_fs(3, 1'b0);
      M_LSL:         fs = alu_fs(4, 1'b0);
      M_LSR:         fs = alu_fs(5, 1'b0);
      M_B, M_ILL:    fs = 5'd0;
      default:       fs = alu_fs(2, 1'b0);
    endcase
    v.cw = {sa, sb, da, rw, mw, fs, bsel, en_mem, en_alu};
    if (v.ldur) v.cw_mem = {sa, sb, da, 1'b1, mw, fs, bsel, 1'b1, en_alu};
    if (m == M_B)
      v.pc_after = pc_now + 64'(longint'($signed(w[25:0])) * 4);
    else if (m == M_CBZ && st[0])
      v.pc_after = pc_now + 64'(longint'($signed(w[23:5])) * 4);
    else
      v.pc_after = pc_now + 64'd4;
    return v;
  endfunction

  task automatic run_instr(input vec_t v, input string tag);
    check({tag, " ready_idle"}, 64'(instr_ready), 64'd1);
    instruction = v.w;
    status      = v.st;
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    check({tag, " exec_cw"}, 64'(ControlWord), 64'(v.cw));
    check({tag, " exec_const"}, constant, v.cst);
    check({tag, " exec_illegal"}, 64'(illegal), 64'(v.ill));
    check({tag, " exec_ready"}, 64'(instr_ready), 64'd0);
    if (v.ldur) begin
      @(negedge clock);
      check({tag, " mem_cw"}, 64'(ControlWord), 64'(v.cw_mem));
      check({tag, " mem_const"}, constant, v.cst);
      check({tag, " mem_ready"}, 64'(instr_ready), 64'd0);
    end
    @(negedge clock);
    check({tag, " idle_cw"}, 64'(ControlWord), 64'd0);
    check({tag, " idle_const"}, constant, 64'd0);
    check({tag, " idle_illegal"}, 64'(illegal), 64'd0);
    check({tag, " pc"}, pc, v.pc_after);
    exp_pc = v.pc_after;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " rst_cw"}, 64'(ControlWord), 64'd0);
    check({tag, " rst_const"}, constant, 64'd0);
    check({tag, " rst_illegal"}, 64'(illegal), 64'd0);
    check({tag, " rst_ready"}, 64'(instr_ready), 64'd1);
    check({tag, " rst_pc"}, pc, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    instr_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_values("do_reset");
    @(negedge clock);
    reset = 1'b1;
    exp_pc = 64'd0;
  endtask

  vec_t        tbl [11];
  vec_t        add_v;
  logic [31:0] w;
  int          cls;
  logic        rw_seen;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{32'h8B000045, 4'b0000, ADD_CW, 25'd0, 64'd0, 1'b0, 1'b0, 64'h4};
    tbl[1]  = '{32'h910013FE, 4'b0000, 25'b11111_00000_11110_1_0_01000_1_0_1, 25'd0, 64'd4, 1'b0, 1'b0, 64'h8};
    tbl[2]  = '{32'hF8408041, 4'b0000, 25'b00010_00000_00001_0_0_01000_1_0_0,
                25'b00010_00000_00001_1_0_01000_1_1_0, 64'd8, 1'b0, 1'b1, 64'hC};
    tbl[3]  = '{32'h8B000045, 4'b0000, ADD_CW, 25'd0, 64'd0, 1'b0, 1'b0, 64'h10};
    tbl[4]  = '{32'hB4000065, 4'b0001, 25'b00101_00000_00000_0_0_01000_1_0_0, 25'd0, 64'd0, 1'b0, 1'b0, 64'h1C};
    tbl[5]  = '{32'hB4000065, 4'b1110, 25'b00101_00000_00000_0_0_01000_1_0_0, 25'd0, 64'd0, 1'b0, 1'b0, 64'h20};
    tbl[6]  = '{32'hF81F8083, 4'b0000, 25'b00100_00011_00000_0_1_01000_1_0_0, 25'd0,
                64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, 64'h24};
    tbl[7]  = '{32'hD13FFC41, 4'b0000, 25'b00010_00000_00001_1_0_01010_1_0_1, 25'd0, 64'hFFF, 1'b0, 1'b0, 64'h28};
    tbl[8]  = '{32'hFFFFFFFF, 4'b0000, 25'd0, 25'd0, 64'd0, 1'b1, 1'b0, 64'h2C};
    tbl[9]  = '{32'hD3400D07, 4'b0000, 25'b01000_00000_00111_1_0_10100_1_0_1, 25'd0, 64'd3, 1'b0, 1'b0, 64'h30};
    tbl[10] = '{32'h17FFFFFE, 4'b0000, 25'd0, 25'd0, 64'd0, 1'b0, 1'b0, 64'h28};
    add_v   = tbl[0];

    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_values("init");
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 11; i++) run_instr(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted in the MEM cycle of a load.
    instruction = 32'hF8408041;
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    check("abort mem_cw", 64'(ControlWord), 64'(25'b00010_00000_00001_1_0_01000_1_1_0));
    #2 reset = 1'b0;
    #1 check_reset_values("abort");
    @(negedge clock);
    reset = 1'b1;
    exp_pc = 64'd0;
    rw_seen = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (ControlWord[9]) rw_seen = 1'b1;
    end
    check("abort no_regwrite", 64'(rw_seen), 64'd0);
    check("abort pc_hold", pc, 64'd0);

    // Backward branch wrapping below zero.
    run_instr(add_v, "b_pre");
    run_instr(model(32'h17FFFFFE, 4'b0000, exp_pc), "b_wrap");
    check("b_wrap literal", pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // CBZ not taken from pc 0x10.
    do_reset();
    repeat (4) run_instr(model(32'h8B000045, 4'b0000, exp_pc), "cbz_pre");
    run_instr(model(32'hB4000065, 4'b0000, exp_pc), "cbz_nt");
    check("cbz_nt literal", pc, 64'h14);

    // Illegal with instr_valid held high through EXEC.
    instruction = 32'hFFFFFFFF;
    instr_valid = 1'b1;
    @(negedge clock);
    instruction = 32'h8B000045;
    check("hold ill_exec", 64'(illegal), 64'd1);
    check("hold ill_cw", 64'(ControlWord), 64'd0);
    check("hold ill_ready", 64'(instr_ready), 64'd0);
    @(negedge clock);
    check("hold idle_illegal", 64'(illegal), 64'd0);
    check("hold idle_cw", 64'(ControlWord), 64'd0);
    check("hold idle_ready", 64'(instr_ready), 64'd1);
    check("hold pc1", pc, exp_pc + 64'd4);
    exp_pc = exp_pc + 64'd4;
    @(negedge clock);
    instr_valid = 1'b0;
    check("hold add_cw", 64'(ControlWord), 64'(ADD_CW));
    check("hold add_ready", 64'(instr_ready), 64'd0);
    @(negedge clock);
    check("hold add_idle_cw", 64'(ControlWord), 64'd0);
    check("hold pc2", pc, exp_pc + 64'd4);
    exp_pc = exp_pc + 64'd4;

    // Randomised instruction mix against the reference model.
    do_reset();
    for (int n = 0; n < 150; n++) begin
      w   = $urandom;
      cls = $urandom_range(0, 13);
      case (cls)
        0:  w = {11'b10001011000, w[20:0]};
        1:  w = {11'b11001011000, w[20:0]};
        2:  w = {11'b10001010000, w[20:0]};
        3:  w = {11'b10101010000, w[20:0]};
        4:  w = {11'b11001010000, w[20:0]};
        5:  w = {11'b11010011011, w[20:0]};
        6:  w = {11'b11010011010, w[20:0]};
        7:  w = {11'b11111000010, w[20:0]};
        8:  w = {11'b11111000000, w[20:0]};
        9:  w = {10'b1001000100, w[21:0]};
        10: w = {10'b1101000100, w[21:0]};
        11: w = {8'b10110100, w[23:0]};
        12: w = {6'b000101, w[25:0]};
        default: ;
      endcase
      run_instr(model(w, 4'($urandom), exp_pc), $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
